reset_ctrl_mdom: RTL and testbench



---
 rtl/reset_ctrl_pkg.sv | 29 ++
 rtl/reset_in_conditioner.sv | 42 ++++
 rtl/reset_ctrl_mdom.sv | 196 +++++++++++++++++++
 tb/tb_reset_ctrl_mdom.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the multi-domain reset controller: register map,
// reset-reason bit positions and POR sequencer state encoding.
package reset_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_CTRL      = 2'd0,
    REG_REASON    = 2'd1,
    REG_STATUS    = 2'd2,
    REG_PULSE_LEN = 2'd3
  } reg_addr_e;

  localparam int RSN_POR     = 0;
  localparam int RSN_EXT     = 1;
  localparam int RSN_NDM     = 2;
  localparam int RSN_SW_BASE = 3;

  localparam int CTRL_ALL_BIT   = 31;
  localparam int STATUS_POR_BIT = 31;

  localparam logic [1:0] POR_WAIT_LOCK   = 2'd0;
  localparam logic [1:0] POR_WAIT_ASSERT = 2'd1;
  localparam logic [1:0] POR_ASSERT      = 2'd2;
  localparam logic [1:0] POR_DONE        = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_in_conditioner.sv
// External reset conditioning: two-flop synchroniser followed by a debouncer
// that only moves its output after DEBOUNCE_CYCLES consecutive agreeing samples.
module reset_in_conditioner
  import reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= RELOAD;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      // any sample matching the current level restarts the stability window
      if (sync_q2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync_q2;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_ctrl_mdom.sv
// Multi-domain reset controller: POR sequencer, external/ndm/software reset
// sources, sticky reset-reason register and a pipelined Wishbone register file.
//
//   state           | meaning
//   ----------------+-------------------------------------------------
//   POR_WAIT_LOCK   | waiting for PLL lock, all domains held in reset
//   POR_WAIT_ASSERT | lock seen, settling for POR_WAIT_CYCLES
//   POR_ASSERT      | POR asserted for POR_ASSERT_CYCLES
//   POR_DONE        | sequence complete, lock loss ignored from here on
module reset_ctrl_mdom
  import reset_ctrl_pkg::*;
#(
  parameter int                     NUM_DOMAINS       = 4,
  parameter logic [NUM_DOMAINS-1:0] DM_DOMAIN_MASK    = NUM_DOMAINS'(1),
  parameter int                     POR_WAIT_CYCLES   = 8,
  parameter int                     POR_ASSERT_CYCLES = 8,
  parameter int                     DEBOUNCE_CYCLES   = 16,
  parameter int                     SW_PULSE_DEFAULT  = 16,
  parameter int                     PULSE_W           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked_i,
  input  logic                   ext_reset_i,
  input  logic                   ndm_reset_i,
  output logic [NUM_DOMAINS-1:0] domain_reset_o,
  output logic                   por_completed_o,
  input  logic [1:0]             wb_adr,
  input  logic [31:0]            wb_dat_w,
  output logic [31:0]            wb_dat_r,
  input  logic [3:0]             wb_sel,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  output logic                   wb_ack,
  output logic                   wb_stall,
  output logic                   wb_err
);

  localparam int POR_CW = $clog2(max2(POR_WAIT_CYCLES, POR_ASSERT_CYCLES) + 1);
  localparam logic [POR_CW-1:0] WAIT_LOAD   = POR_CW'(POR_WAIT_CYCLES - 1);
  localparam logic [POR_CW-1:0] ASSERT_LOAD = POR_CW'(POR_ASSERT_CYCLES - 1);
  localparam int RSN_W = RSN_SW_BASE + NUM_DOMAINS;

  logic [1:0]             por_state;
  logic [POR_CW-1:0]      por_cnt;
  logic                   por_done;
  logic                   ext_cond;
  logic [NUM_DOMAINS-1:0] sw_active;
  logic [NUM_DOMAINS-1:0] sw_trig;
  logic [PULSE_W-1:0]     pulse_len;
  logic [PULSE_W-1:0]     sw_load;
  logic [RSN_W-1:0]       reason;
  logic [RSN_W-1:0]       reason_set;
  logic [RSN_W-1:0]       reason_clr;
  logic                   ack_q;
  logic [31:0]            rd_data;
  reg_addr_e              adr;
  logic                   access;
  logic                   wr;
  logic                   unused_wb;

  // ---------------- POR sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      por_state <= POR_WAIT_LOCK;
      por_cnt   <= '0;
    end else begin
      case (por_state)
        POR_WAIT_LOCK: begin
          if (pll_locked_i) begin
            por_state <= POR_WAIT_ASSERT;
            por_cnt   <= WAIT_LOAD;
          end
        end
        POR_WAIT_ASSERT: begin
          if (!pll_locked_i) begin
            por_state <= POR_WAIT_LOCK;
          end else if (por_cnt == '0) begin
            por_state <= POR_ASSERT;
            por_cnt   <= ASSERT_LOAD;
          end else begin
            por_cnt <= por_cnt - POR_CW'(1);
          end
        end
        POR_ASSERT: begin
          if (!pll_locked_i) begin
            por_state <= POR_WAIT_LOCK;
          end else if (por_cnt == '0) begin
            por_state <= POR_DONE;
          end else begin
            por_cnt <= por_cnt - POR_CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign por_done        = (por_state == POR_DONE);
  assign por_completed_o = por_done;

  // ---------------- external reset ----------------
  reset_in_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ext_cond (
    .clk     (clk),
    .rst     (rst),
    .async_in(ext_reset_i),
    .level   (ext_cond)
  );

  // ---------------- bus decode ----------------
  assign adr    = reg_addr_e'(wb_adr);
  assign access = wb_cyc & wb_stb;
  assign wr     = access & wb_we;

  assign sw_trig = (wr && adr == REG_CTRL)
                 ? (wb_dat_w[NUM_DOMAINS-1:0] | {NUM_DOMAINS{wb_dat_w[CTRL_ALL_BIT]}})
                 : '0;
  assign sw_load = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

  // ---------------- per-domain software pulses and outputs ----------------
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    logic [PULSE_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (sw_trig[i]) begin
        cnt <= sw_load;
      end else if (cnt != '0) begin
        cnt <= cnt - PULSE_W'(1);
      end
    end

    assign sw_active[i]      = (cnt != '0);
    assign domain_reset_o[i] = ~por_done | ext_cond
                             | (ndm_reset_i & ~DM_DOMAIN_MASK[i]) | sw_active[i];
  end

  // ---------------- registers ----------------
  always_comb begin
    reason_set                                = '0;
    reason_set[RSN_POR]                       = (por_state == POR_ASSERT);
    reason_set[RSN_EXT]                       = ext_cond;
    reason_set[RSN_NDM]                       = ndm_reset_i;
    reason_set[RSN_SW_BASE +: NUM_DOMAINS]    = sw_trig;
  end

  assign reason_clr = (wr && adr == REG_REASON) ? wb_dat_w[RSN_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      reason    <= '0;
      pulse_len <= PULSE_W'(SW_PULSE_DEFAULT);
    end else begin
      // a new event wins over a simultaneous clear
      reason <= (reason & ~reason_clr) | reason_set;
      if (wr && adr == REG_PULSE_LEN) begin
        pulse_len <= wb_dat_w[PULSE_W-1:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (adr)
      REG_REASON: rd_data = 32'(reason);
      REG_STATUS: begin
        rd_data[NUM_DOMAINS-1:0] = domain_reset_o;
        rd_data[STATUS_POR_BIT]  = por_completed_o;
      end
      REG_PULSE_LEN: rd_data = 32'(pulse_len);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      wb_dat_r <= '0;
    end else begin
      ack_q <= access;
      if (access) begin
        wb_dat_r <= rd_data;
      end
    end
  end

  assign wb_ack    = ack_q & wb_cyc;
  assign wb_stall  = 1'b0;
  assign wb_err    = 1'b0;
  assign unused_wb = ^{wb_sel, wb_dat_w};

endmodule

// File: tb/tb_reset_ctrl_mdom.sv
// Scenario bench for reset_ctrl_mdom with a cycle-level behavioural model of
// the reset sources and registers.
module tb_reset_ctrl_mdom;
  import reset_ctrl_pkg::*;

  localparam int ND   = 4;
  localparam int WAIT = 8;
  localparam int ASRT = 8;
  localparam int DEB  = 16;
  localparam int PDEF = 16;
  localparam int PW   = 8;
  localparam logic [ND-1:0] DM_MASK = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll = 1'b0;
  logic          ext = 1'b0;
  logic          ndm = 1'b0;
  logic [ND-1:0] domain_reset_o;
  logic          por_completed_o;
  logic [1:0]    wb_adr = '0;
  logic [31:0]   wb_dat_w = '0;
  logic [31:0]   wb_dat_r;
  logic [3:0]    wb_sel = 4'hF;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic          wb_ack;
  logic          wb_stall;
  logic          wb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_ctrl_mdom #(
    .NUM_DOMAINS(ND), .DM_DOMAIN_MASK(DM_MASK), .POR_WAIT_CYCLES(WAIT),
    .POR_ASSERT_CYCLES(ASRT), .DEBOUNCE_CYCLES(DEB), .SW_PULSE_DEFAULT(PDEF), .PULSE_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked_i(pll), .ext_reset_i(ext), .ndm_reset_i(ndm),
    .domain_reset_o(domain_reset_o), .por_completed_o(por_completed_o),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  // ---------------- reference model ----------------
  int          m_cyc = 0;
  bit          m_por_started = 0;
  int          m_por_start = 0;
  bit [ND+2:0] m_reason = '0;
  int          m_pulse = PDEF;
  int          m_sw_end [ND];
  bit          m_s1 = 0, m_s2 = 0, m_level = 0, m_run_val = 0;
  int          m_run_len = 0;

  function automatic bit m_done();
    return m_por_started && (m_cyc - m_por_start >= WAIT + ASRT);
  endfunction

  function automatic logic [ND-1:0] m_dom();
    logic [ND-1:0] r;
    for (int i = 0; i < ND; i++)
      r[i] = !m_done() || m_level || (ndm && !DM_MASK[i]) || (m_cyc < m_sw_end[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    bit          acc_w;
    bit [ND-1:0] trig;
    bit [ND+2:0] setv, clrv;
    bit          cur;
    int          age;
    m_cyc++;
    if (rst) begin
      m_por_started = 0;
      m_reason = '0;
      m_pulse = PDEF;
      for (int i = 0; i < ND; i++) m_sw_end[i] = 0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run_val = 0; m_run_len = 0;
    end else begin
      acc_w = wb_cyc && wb_stb && wb_we;
      trig = '0;
      if (acc_w && wb_adr == 2'd0) trig = wb_dat_w[ND-1:0] | {ND{wb_dat_w[31]}};
      setv = '0;
      age = m_cyc - 1 - m_por_start;
      if (m_por_started && age >= WAIT && age < WAIT + ASRT) setv[0] = 1;
      setv[1] = m_level;
      setv[2] = ndm;
      for (int i = 0; i < ND; i++)
        if (trig[i]) begin
          setv[3+i] = 1;
          m_sw_end[i] = m_cyc + ((m_pulse == 0) ? 1 : m_pulse);
        end
      clrv = (acc_w && wb_adr == 2'd1) ? wb_dat_w[ND+2:0] : '0;
      m_reason = (m_reason & ~clrv) | setv;
      if (acc_w && wb_adr == 2'd3) m_pulse = int'(wb_dat_w[PW-1:0]);
      if (!m_por_started && pll) begin
        m_por_started = 1;
        m_por_start = m_cyc;
      end
      cur = m_s2; m_s2 = m_s1; m_s1 = ext;
      if (cur == m_run_val && m_run_len > 0) m_run_len++;
      else begin m_run_val = cur; m_run_len = 1; end
      if (m_run_len >= DEB && m_run_val != m_level) m_level = m_run_val;
    end
  end

  // ---------------- bus helpers (no checking) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, output logic ack);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = a; wb_dat_w = d;
    @(negedge clk);
    ack = wb_ack;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d, output logic ack);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = a;
    @(negedge clk);
    d = wb_dat_r; ack = wb_ack;
    wb_cyc = 0; wb_stb = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic ack;
    rst = 1;
    repeat (3) tick();
    checks++; if (domain_reset_o !== '1) begin errors++; $display("FAIL rst_dom got %b exp 1111", domain_reset_o); end
    checks++; if (por_completed_o !== 1'b0) begin errors++; $display("FAIL rst_por got %b exp 0", por_completed_o); end
    checks++; if (wb_ack !== 1'b0 || wb_stall !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL rst_bus ack/stall/err got %b%b%b exp 000", wb_ack, wb_stall, wb_err); end
    rst = 0;
    wb_read(2'd1, d, ack);
    checks++; if (ack !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rst_reason got ack=%b d=%h exp ack=1 d=0", ack, d); end
    wb_read(2'd3, d, ack);
    checks++; if (d !== 32'(PDEF)) begin errors++; $display("FAIL rst_pulse_len got %h exp %h", d, PDEF); end
    wb_read(2'd2, d, ack);
    checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL rst_status got %h exp 0000000f", d); end
  endtask

  task automatic test_por();
    logic [31:0] d; logic ack;
    repeat (5) tick();
    pll = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (por_completed_o !== (k >= 17)) begin errors++; $display("FAIL por_done k=%0d got %b exp %b", k, por_completed_o, (k >= 17)); end
      checks++; if (domain_reset_o !== ((k >= 17) ? 4'b0000 : 4'b1111)) begin errors++; $display("FAIL por_dom k=%0d got %b", k, domain_reset_o); end
    end
    wb_read(2'd1, d, ack);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL por_reason got %h exp 1", d); end
  endtask

  task automatic test_sw();
    logic [31:0] d, exp; logic ack; int hi, other;
    wb_write(2'd3, 32'd5, ack);
    wb_write(2'd0, 32'h4, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sw_ack got %b exp 1", ack); end
    hi = 0; other = 0;
    for (int k = 0; k < 10; k++) begin
      if (domain_reset_o[2]) hi++;
      if (domain_reset_o[1:0] != 0 || domain_reset_o[3]) other++;
      tick();
    end
    checks++; if (hi != 5 || other != 0) begin errors++; $display("FAIL sw_pulse5 got hi=%0d other=%0d exp 5/0", hi, other); end
    exp = 32'(m_reason);
    wb_read(2'd1, d, ack);
    checks++; if (d[5] !== 1'b1 || d !== exp) begin errors++; $display("FAIL sw_reason got %h exp %h", d, exp); end
    wb_write(2'd3, 32'd0, ack);
    wb_write(2'd0, 32'h4, ack);
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      if (domain_reset_o[2]) hi++;
      tick();
    end
    checks++; if (hi != 1) begin errors++; $display("FAIL sw_pulse0 got hi=%0d exp 1", hi); end
    for (int it = 0; it < 6; it++) begin
      int plen;
      plen = $urandom_range(0, 20);
      wb_write(2'd3, 32'(plen) | ($urandom & 32'hFFFF_FF00), ack);
      d = ($urandom & 32'h7FFF_FFF0) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d[31] = 1'b1;
      wb_write(2'd0, d, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sw_rand_ack it=%0d got %b exp 1", it, ack); end
      for (int k = 0; k < 24; k++) begin
        checks++; if (domain_reset_o !== m_dom()) begin errors++; $display("FAIL sw_rand_dom it=%0d k=%0d got %b exp %b", it, k, domain_reset_o, m_dom()); end
        tick();
      end
      wb_read(2'd3, d, ack);
      checks++; if (d !== 32'(plen)) begin errors++; $display("FAIL sw_rand_plen got %h exp %h", d, plen); end
      exp = 32'(m_reason);
      wb_read(2'd1, d, ack);
      checks++; if (d !== exp) begin errors++; $display("FAIL sw_rand_reason got %h exp %h", d, exp); end
    end
  endtask

  task automatic test_ndm();
    logic [31:0] d; logic ack; int hi, bad;
    hi = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      ndm = (k < 3);
      #1;
      if (domain_reset_o == 4'b1110) hi++;
      if (domain_reset_o[0]) bad++;
      tick();
    end
    checks++; if (hi != 3 || bad != 0) begin errors++; $display("FAIL ndm_pulse got hi=%0d dom0=%0d exp 3/0", hi, bad); end
    wb_read(2'd1, d, ack);
    checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL ndm_reason got %h exp bit2 set", d); end
    for (int k = 0; k < 40; k++) begin
      ndm = 1'($urandom_range(0, 1));
      #1;
      checks++; if (domain_reset_o !== m_dom()) begin errors++; $display("FAIL ndm_rand k=%0d got %b exp %b", k, domain_reset_o, m_dom()); end
      tick();
    end
    ndm = 0;
    tick();
  endtask

  task automatic test_ext();
    logic [31:0] d, exp; logic ack; int hi, first;
    ext = 1;
    repeat (10) tick();
    ext = 0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (domain_reset_o != 0) hi++;
      tick();
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL ext_glitch got %0d reset cycles exp 0", hi); end
    ext = 1; first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (first < 0 && domain_reset_o == 4'b1111) first = k;
    end
    checks++; if (first != 2 + DEB) begin errors++; $display("FAIL ext_assert_delay got %0d exp %0d", first, 2 + DEB); end
    ext = 0; first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (first < 0 && domain_reset_o == 4'b0000) first = k;
    end
    checks++; if (first != 2 + DEB) begin errors++; $display("FAIL ext_release_delay got %0d exp %0d", first, 2 + DEB); end
    for (int it = 0; it < 4; it++) begin
      int len;
      len = $urandom_range(5, 30);
      for (int k = 0; k < len + 40; k++) begin
        ext = (k < len);
        checks++; if (domain_reset_o !== m_dom()) begin errors++; $display("FAIL ext_rand it=%0d k=%0d got %b exp %b", it, k, domain_reset_o, m_dom()); end
        tick();
      end
    end
    exp = 32'(m_reason);
    wb_read(2'd1, d, ack);
    checks++; if (d[1] !== 1'b1 || d !== exp) begin errors++; $display("FAIL ext_reason got %h exp %h", d, exp); end
  endtask

  task automatic test_clear_race();
    logic [31:0] d, exp; logic ack; int cnt;
    wb_write(2'd0, 32'h1, ack);
    repeat (30) tick();
    ndm = 1;
    wb_write(2'd1, 32'hF, ack);
    ndm = 0;
    exp = 32'(m_reason);
    wb_read(2'd1, d, ack);
    checks++; if ((d & 32'hF) !== 32'h4) begin errors++; $display("FAIL race_low_bits got %h exp 4", d & 32'hF); end
    checks++; if (d !== exp) begin errors++; $display("FAIL race_reason got %h exp %h", d, exp); end
    wb_write(2'd3, 32'd6, ack);
    cnt = 0;
    wb_write(2'd0, 32'h2, ack);
    if (domain_reset_o[1]) cnt++;
    tick(); if (domain_reset_o[1]) cnt++;
    tick(); if (domain_reset_o[1]) cnt++;
    wb_write(2'd0, 32'h2, ack);
    if (domain_reset_o[1]) cnt++;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (domain_reset_o[1]) cnt++;
    end
    checks++; if (cnt != 9) begin errors++; $display("FAIL retrigger_len got %0d exp 9", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, exp;
    v = 32'($urandom_range(1, 255));
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 2'd3; wb_dat_w = v;
    tick();
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_wr_ack got %b exp 1", wb_ack); end
    wb_we = 0; wb_adr = 2'd3;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_dat_r !== v) begin errors++; $display("FAIL b2b_rd_plen got ack=%b d=%h exp 1/%h", wb_ack, wb_dat_r, v); end
    exp = {m_done(), 27'b0, m_dom()};
    wb_adr = 2'd2;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_dat_r !== exp) begin errors++; $display("FAIL b2b_rd_status got ack=%b d=%h exp 1/%h", wb_ack, wb_dat_r, exp); end
    wb_cyc = 0; wb_stb = 0;
    tick();
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack got %b exp 0", wb_ack); end
    wb_cyc = 1; wb_stb = 1; wb_adr = 2'd1;
    tick();
    wb_cyc = 0; wb_stb = 0;
    #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_cyc_gate got %b exp 0", wb_ack); end
    tick();
  endtask

  task automatic test_rst_mid();
    logic [31:0] d; logic ack;
    wb_write(2'd3, 32'd50, ack);
    wb_write(2'd0, 32'h8, ack);
    repeat (5) tick();
    checks++; if (domain_reset_o[3] !== 1'b1) begin errors++; $display("FAIL mid_sw_active got %b exp 1", domain_reset_o[3]); end
    rst = 1;
    tick(); tick();
    checks++; if (domain_reset_o !== 4'b1111 || por_completed_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b/%b exp 1111/0", domain_reset_o, por_completed_o); end
    rst = 0;
    wb_read(2'd1, d, ack);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_reason got %h exp 0", d); end
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (por_completed_o !== (k >= 17)) begin errors++; $display("FAIL rst_por_restart k=%0d got %b exp %b", k, por_completed_o, (k >= 17)); end
      checks++; if (domain_reset_o !== ((k >= 17) ? 4'b0000 : 4'b1111)) begin errors++; $display("FAIL rst_dom_restart k=%0d got %b", k, domain_reset_o); end
    end
    wb_read(2'd1, d, ack);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_reason_after got %h exp 1", d); end
    wb_read(2'd3, d, ack);
    checks++; if (d !== 32'(PDEF)) begin errors++; $display("FAIL rst_plen_after got %h exp %h", d, PDEF); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_por();
    test_sw();
    test_ndm();
    test_ext();
    test_clear_race();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
